// File: rtl/hc595_rx_decoder.sv
// hc595_rx_decoder: rebuilds a 74HC595 chain from ds_data/ds_shcp/ds_stcp and decodes {sel,seg} frames into a 6-digit BCD image.
//   in : clk, rst (sync, active-high), ds_data, ds_shcp, ds_stcp (async to clk)
//   out: par_q {sel,seg}, latch_vld/frame_err (latch stage), dig_vld/dec_err/dig_idx/dig_val/dig_dp (decode stage), disp_bcd
module hc595_rx_decoder #(
  parameter int SHIFT_W = 16,
  parameter int NUM_DIG = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds_data,
  input  logic                   ds_shcp,
  input  logic                   ds_stcp,
  output logic [SHIFT_W-1:0]     par_q,
  output logic                   latch_vld,
  output logic                   frame_err,
  output logic                   dig_vld,
  output logic [2:0]             dig_idx,
  output logic [3:0]             dig_val,
  output logic                   dig_dp,
  output logic                   dec_err,
  output logic [4*NUM_DIG-1:0]   disp_bcd
);
  logic [2:0] s1, s2, s3;
  logic [SHIFT_W-1:0] shreg;
  logic [4:0] bit_cnt;
  logic sh_rise, st_rise, seg_ok, dec_ok;
  logic [3:0] seg_val;
  logic [2:0] sel_idx, zeros;
  assign sh_rise = s2[1] & ~s3[1];
  assign st_rise = s2[2] & ~s3[2];
  always_comb begin
    seg_ok = 1'b1;
    seg_val = 4'd0;
    case (par_q[6:0])
      7'h40: seg_val = 4'd0;
      7'h79: seg_val = 4'd1;
      7'h24: seg_val = 4'd2;
      7'h30: seg_val = 4'd3;
      7'h19: seg_val = 4'd4;
      7'h12: seg_val = 4'd5;
      7'h02: seg_val = 4'd6;
      7'h78: seg_val = 4'd7;
      7'h00: seg_val = 4'd8;
      7'h10: seg_val = 4'd9;
      default: seg_ok = 1'b0;
    endcase
  end
  // Active-low one-hot select: legal only with exactly one zero among the digit lines.
  always_comb begin
    zeros = 3'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (!par_q[SHIFT_W/2+i]) begin
        zeros = zeros + 3'd1;
        sel_idx = 3'(i);
      end
  end
  assign dec_ok = seg_ok && zeros == 3'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      par_q <= '0;
      latch_vld <= 1'b0;
      frame_err <= 1'b0;
      dig_vld <= 1'b0;
      dec_err <= 1'b0;
      dig_idx <= '0;
      dig_val <= '0;
      dig_dp <= 1'b0;
      disp_bcd <= '0;
    end else begin
      s1 <= {ds_stcp, ds_shcp, ds_data};
      s2 <= s1;
      s3 <= s2;
      latch_vld <= st_rise;
      frame_err <= st_rise && bit_cnt != 5'(SHIFT_W);
      dig_vld <= latch_vld && dec_ok;
      dec_err <= latch_vld && !dec_ok;
      if (sh_rise) shreg <= {shreg[SHIFT_W-2:0], s2[0]};
      if (st_rise) par_q <= shreg;
      // A shift coinciding with the latch belongs to the next frame.
      bit_cnt <= st_rise ? {4'd0, sh_rise} : (sh_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
      if (latch_vld && dec_ok) begin
        dig_idx <= sel_idx;
        dig_val <= seg_val;
        dig_dp <= ~par_q[7];
        disp_bcd[{sel_idx, 2'b00} +: 4] <= seg_val;
      end
    end
  end
endmodule

// File: tb/tb_hc595_rx_decoder.sv
// tb_hc595_rx_decoder: drives 595 link waveforms and checks latch/decode outputs against a frame-level model.
module tb_hc595_rx_decoder;
  logic clk = 1'b0, rst = 1'b1, ds_data = 1'b0, ds_shcp = 1'b0, ds_stcp = 1'b0;
  logic [15:0] par_q;
  logic latch_vld, frame_err, dig_vld, dig_dp, dec_err;
  logic [2:0] dig_idx;
  logic [3:0] dig_val;
  logic [23:0] disp_bcd;
  int tests = 0, fails = 0;
  logic [15:0] m_sh = '0;
  int m_cnt = 0;
  logic [2:0] m_idx = '0;
  logic [3:0] m_val = '0;
  logic m_dp = 1'b0;
  logic [23:0] m_disp = '0;
  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  hc595_rx_decoder dut (.clk(clk), .rst(rst), .ds_data(ds_data), .ds_shcp(ds_shcp), .ds_stcp(ds_stcp),
    .par_q(par_q), .latch_vld(latch_vld), .frame_err(frame_err), .dig_vld(dig_vld), .dig_idx(dig_idx),
    .dig_val(dig_val), .dig_dp(dig_dp), .dec_err(dec_err), .disp_bcd(disp_bcd));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_shift(input logic b);
    m_sh = {m_sh[14:0], b};
    m_cnt = m_cnt < 31 ? m_cnt + 1 : 31;
  endtask

  task automatic model_reset();
    m_sh = '0; m_cnt = 0; m_idx = '0; m_val = '0; m_dp = 1'b0; m_disp = '0;
  endtask

  task automatic shift_bit(input logic b);
    ds_data = b;
    repeat (4) @(negedge clk);
    ds_shcp = 1'b1;
    model_shift(b);
    repeat (4) @(negedge clk);
    ds_shcp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = n - 1 - i;
      shift_bit(k < 16 ? w[k] : 1'($urandom));
    end
  endtask

  task automatic do_latch(input logic with_shift, input logic b);
    logic [15:0] epar;
    logic eferr, ok;
    logic [2:0] eidx;
    logic [3:0] eval;
    int n, z;
    if (with_shift) begin
      ds_data = b;
      repeat (4) @(negedge clk);
      ds_shcp = 1'b1;
    end
    ds_stcp = 1'b1;
    epar = m_sh;
    eferr = m_cnt != 16;
    if (with_shift) begin
      m_sh = {m_sh[14:0], b};
      m_cnt = 1;
    end else m_cnt = 0;
    eval = 4'd0;
    ok = 1'b0;
    for (int v = 0; v < 10; v++) if (segs[v] == epar[6:0]) begin ok = 1'b1; eval = 4'(v); end
    z = 0;
    eidx = 3'd0;
    for (int d = 0; d < 6; d++) if (!epar[8+d]) begin z++; eidx = 3'(d); end
    ok = ok && z == 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!latch_vld && n < 8);
    check("latch_seen", {31'd0, latch_vld}, 32'd1);
    check("par_q", {16'd0, par_q}, {16'd0, epar});
    check("frame_err", {31'd0, frame_err}, {31'd0, eferr});
    @(negedge clk);
    if (ok) begin
      m_idx = eidx; m_val = eval; m_dp = ~epar[7];
      m_disp[4*eidx +: 4] = eval;
    end
    check("latch_pulse", {31'd0, latch_vld}, 32'd0);
    check("dig_vld", {31'd0, dig_vld}, {31'd0, ok});
    check("dec_err", {31'd0, dec_err}, {31'd0, !ok});
    check("dig_idx", {29'd0, dig_idx}, {29'd0, m_idx});
    check("dig_val", {28'd0, dig_val}, {28'd0, m_val});
    check("dig_dp", {31'd0, dig_dp}, {31'd0, m_dp});
    check("disp_bcd", {8'd0, disp_bcd}, {8'd0, m_disp});
    @(negedge clk);
    check("dig_pulse", {30'd0, dig_vld, dec_err}, 32'd0);
    @(negedge clk);
    ds_stcp = 1'b0;
    ds_shcp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    send_bits(w, n);
    do_latch(1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      ds_data = ~ds_data; ds_shcp = ~ds_shcp; ds_stcp = ~ds_stcp;
    end
    @(negedge clk);
    ds_data = 1'b0; ds_shcp = 1'b0; ds_stcp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("rst_pulses", {28'd0, latch_vld, frame_err, dig_vld, dec_err}, 32'd0);
    end
    check("rst_par_q", {16'd0, par_q}, 32'd0);
    check("rst_digit", {24'd0, dig_idx, dig_val, dig_dp}, 32'd0);
    check("rst_disp", {8'd0, disp_bcd}, 32'd0);

    frame(16'hFEC0, 16);
    frame(16'hDF12, 16);
    check("disp_d5", {28'd0, disp_bcd[23:20]}, 32'd5);
    frame(16'hFD79, 12);
    frame(16'hFB24, 40);
    frame(16'hFEFF, 16);
    frame(16'hFCC0, 16);
    send_bits(16'hF7B0, 16);
    do_latch(1'b1, 1'b1);
    check("combo_par", {16'd0, par_q}, 32'h0000F7B0);
    send_bits(16'hEF19, 15);
    do_latch(1'b0, 1'b0);
    check("combo_ferr", {31'd0, frame_err}, 32'd0);

    send_bits(16'h00A5, 8);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_par", {16'd0, par_q}, 32'd0);
    check("mid_rst_disp", {8'd0, disp_bcd}, 32'd0);
    frame(16'hF702, 16);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] sel, seg;
      int n;
      sel = $urandom_range(0, 3) == 0 ? 8'($urandom) : {2'($urandom), ~(6'b1 << $urandom_range(0, 5))};
      seg = $urandom_range(0, 3) == 0 ? 8'($urandom) : {1'($urandom), segs[$urandom_range(0, 9)]};
      n = $urandom_range(0, 2) == 0 ? $urandom_range(10, 20) : 16;
      frame({sel, seg}, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hc595_rx_decoder.md
# hc595_rx_decoder

Receive-side model and decoder for the 74HC595 serial display link (ds_data / ds_shcp / ds_stcp) driven by the seven-segment clock transmitter. It samples the three link lines in the system clock domain and rebuilds the shift and storage registers of the 595 chain. On every storage latch it decodes the segment byte to a BCD digit and the select byte to a digit index, keeping a 6-digit display image. It serves as the monitor/scoreboard front end in display benches and as a synthesizable loopback checker on the board.

## Interface
- SHIFT_W, 16: bits per latched frame; the parallel word is {sel[7:0], seg[7:0]}.
- NUM_DIG, 6: digits held in the display image.
- clk  in  1  system clock; all logic rises on clk.
- rst  in  1  synchronous, active-high reset.
- ds_data  in  1  serial data; asynchronous to clk.
- ds_shcp  in  1  shift clock; asynchronous to clk.
- ds_stcp  in  1  storage (latch) clock; asynchronous to clk.
- par_q  out  16  storage register contents, {sel, seg}.
- latch_vld  out  1  one-cycle pulse when par_q updates.
- frame_err  out  1  registered with latch_vld; bit count since last latch != SHIFT_W.
- dig_vld  out  1  one-cycle pulse, one cycle after latch_vld, when decode succeeded.
- dig_idx  out  3  decoded digit index, 0..NUM_DIG-1.
- dig_val  out  4  decoded BCD value, 0..9.
- dig_dp  out  1  decimal point; seg[7] is active-low, so dig_dp = ~seg[7].
- dec_err  out  1  one-cycle pulse, one cycle after latch_vld, when seg or sel is illegal.
- disp_bcd  out  24  display image; digit i occupies [4i+3:4i].

## Operation
- Input conditioning: each ds_* line passes through a 2-flop synchronizer (s1, s2) and a third flop s3. Rising edge = s2 & ~s3.
- Shift: on a shcp rising edge, shreg <= {shreg[14:0], data_s2}. The transmitter sends MSB first: sel[7] first, seg[0] last.
- bit_cnt is 5 bits, saturates at 31, and clears on each latch.
- Latch: on a stcp rising edge:
  - par_q <= shreg.
  - latch_vld = 1.
  - frame_err = (bit_cnt != SHIFT_W).
  - bit_cnt <= 0.
- Simultaneous shcp and stcp edges in the same cycle, matching 595 behaviour:
  - par_q captures the pre-shift shreg.
  - The shift still occurs.
  - bit_cnt <= 1.
- Segment decode uses common-anode, active-low encoding {dp,g,f,e,d,c,b,a} and compares seg[6:0] only:
  - 0:40h, 1:79h, 2:24h, 3:30h, 4:19h
  - 5:12h, 6:02h, 7:78h, 8:00h, 9:10h
  - Any other pattern is illegal.
- Select decode: sel[5:0] is active-low one-hot, and exactly one zero is legal; dig_idx is the position of that zero. sel[7:6] are ignored.
- Decode is registered one cycle after latch_vld:
  - If both seg and sel are legal: dig_vld = 1 and disp_bcd[dig_idx] <= dig_val.
  - Otherwise: dec_err = 1, and disp_bcd and dig_* hold their values.
  - frame_err does not block decode.
- Reset values: every flop, including the synchronizers, clears.
  - par_q = 0000h, disp_bcd = 0.
  - All pulses = 0.
  - dig_idx = 0, dig_val = 0, dig_dp = 0.
  - bit_cnt = 0, shreg = 0.
- Reset in mid-frame discards the partial frame. The first stcp edge after release reports frame_err unless exactly SHIFT_W shifts occurred after release.

## Timing
- Line sampled high by s1 at clk edge N → edge detected in cycle N+1 → shreg/par_q/latch_vld update at edge N+2.
- dig_vld, dec_err, dig_* and disp_bcd update at edge N+3.
- Latency from stcp pin to decoded digit: 3 clk cycles, plus up to 1 cycle of sampling uncertainty.
- ds_shcp and ds_stcp must each stay high and low for at least 3 clk cycles.
- ds_data must be stable from 3 clk cycles before to 1 cycle after each shcp rising edge. Violations are undefined.
- Back-to-back latches are permitted at any spacing that meets the pulse-width rule. Each produces its own latch_vld and decode pulses.

## Test plan
- Reset: hold rst 3 cycles, then toggle the lines → all outputs at reset values; no pulses until the first stcp edge.
- Frame {FEh, C0h}, 16 shifts, then latch → par_q = FEC0h, frame_err = 0; next cycle dig_vld = 1, dig_idx = 0, dig_val = 0, dig_dp = 0.
- Frame {DFh, 12h} → dig_idx = 5, dig_val = 5, dig_dp = 1, disp_bcd[23:20] = 5.
- 12 shifts, then latch → frame_err = 1; bit_cnt saturates at 31 on a 40-shift frame → frame_err = 1.
- Frame {FEh, FFh} and frame {FCh, C0h} → dec_err = 1, disp_bcd unchanged.
- Same-cycle shcp and stcp edges → par_q = previous shreg; the next frame needs only 15 further shifts for frame_err = 0. Assert rst after 8 shifts → shreg and bit_cnt clear, next full frame decodes cleanly.
